// File: rtl/ov7670_config_sequencer_if.sv
// rtl/ov7670_config_sequencer_if.sv - SCCB register-write command/response handshake
interface ov7670_config_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_data;
    logic       resp_valid;
    logic       resp_nack;

    modport master (
        output cmd_valid, cmd_reg, cmd_data,
        input  cmd_ready, resp_valid, resp_nack
    );

    modport slave (
        input  cmd_valid, cmd_reg, cmd_data,
        output cmd_ready, resp_valid, resp_nack
    );
endinterface

// File: rtl/ov7670_config_sequencer.sv
// rtl/ov7670_config_sequencer.sv - walks a selectable OV7670 register table into the SCCB write engine
module ov7670_config_sequencer #(
    parameter int ADDR_W       = 8,
    parameter int NUM_MODES    = 2,
    parameter int DELAY_CYCLES = 1000000,
    parameter int MAX_RETRY    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                mode,
    ov7670_config_sequencer_if.master sccb,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [ADDR_W-1:0]         fail_idx
);
    localparam int CNT_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [15:0] ENTRY_END   = 16'hFFFF;
    localparam logic [15:0] ENTRY_DELAY = 16'hFFF0;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_RESP, S_DELAY, S_DONE, S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [7:0]        cmd_reg_q, cmd_reg_d;
    logic [7:0]        cmd_data_q, cmd_data_d;
    logic [ADDR_W-1:0] fail_idx_q, fail_idx_d;
    logic [15:0]       rom_q;
    logic              advance;

    // Mode 1 (QVGA) differs from mode 0 (VGA) only in scaling/COM14 and the pclk divider.
    function automatic logic [15:0] rom_lookup(input logic [1:0] m, input logic [ADDR_W-1:0] a);
        logic [15:0] e;
        case (int'(a))
            0:       e = 16'h1280;
            1:       e = ENTRY_DELAY;
            2:       e = 16'h1200;
            3:       e = 16'h8C00;
            4:       e = 16'h3A04;
            5:       e = 16'h40D0;
            6:       e = 16'h1100;
            7:       e = 16'h0C00;
            8:       e = 16'h3E00;
            9:       e = 16'h1713;
            10:      e = 16'h1801;
            11:      e = 16'h32B6;
            12:      e = 16'h1902;
            13:      e = 16'h1A7A;
            14:      e = 16'h703A;
            15:      e = 16'h7135;
            16:      e = 16'h7211;
            17:      e = 16'h73F0;
            default: e = ENTRY_END;
        endcase
        if (m == 2'd1) begin
            case (int'(a))
                7:       e = 16'h0C04;
                8:       e = 16'h3E19;
                17:      e = 16'h73F1;
                default: ;
            endcase
        end
        return e;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            retry_q     <= '0;
            cnt_q       <= '0;
            mode_q      <= '0;
            cmd_valid_q <= 1'b0;
            cmd_reg_q   <= '0;
            cmd_data_q  <= '0;
            fail_idx_q  <= '0;
            rom_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            retry_q     <= retry_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_reg_q   <= cmd_reg_d;
            cmd_data_q  <= cmd_data_d;
            fail_idx_q  <= fail_idx_d;
            rom_q       <= rom_lookup(mode_q, idx_q);
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        retry_d     = retry_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        cmd_valid_d = cmd_valid_q;
        cmd_reg_d   = cmd_reg_q;
        cmd_data_d  = cmd_data_q;
        fail_idx_d  = fail_idx_q;
        advance     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    mode_d     = mode;
                    idx_d      = '0;
                    retry_d    = '0;
                    fail_idx_d = '0;
                    state_d    = (int'(mode) >= NUM_MODES) ? S_ERROR : S_FETCH;
                end
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (rom_q == ENTRY_END) begin
                    state_d = S_DONE;
                end else if (rom_q == ENTRY_DELAY) begin
                    cnt_d   = CNT_W'(DELAY_CYCLES - 1);
                    state_d = S_DELAY;
                end else begin
                    cmd_reg_d   = rom_q[15:8];
                    cmd_data_d  = rom_q[7:0];
                    cmd_valid_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (sccb.cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                if (sccb.resp_valid) begin
                    if (!sccb.resp_nack) begin
                        retry_d = '0;
                        advance = 1'b1;
                    end else if (int'(retry_q) < MAX_RETRY) begin
                        // Payload registers are untouched, so the re-issue repeats the same write.
                        retry_d     = retry_q + 1'b1;
                        cmd_valid_d = 1'b1;
                        state_d     = S_ISSUE;
                    end else begin
                        fail_idx_d = idx_q;
                        state_d    = S_ERROR;
                    end
                end
            end
            S_DELAY: begin
                if (cnt_q == '0) advance = 1'b1;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        // A full table stops at the last index rather than wrapping back to entry 0.
        if (advance) begin
            if (idx_q == {ADDR_W{1'b1}}) begin
                state_d = S_DONE;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = S_FETCH;
            end
        end
    end

    assign sccb.cmd_valid = cmd_valid_q;
    assign sccb.cmd_reg   = cmd_reg_q;
    assign sccb.cmd_data  = cmd_data_q;
    assign busy     = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_ISSUE) ||
                      (state_q == S_WAIT_RESP) || (state_q == S_DELAY);
    assign done     = (state_q == S_DONE);
    assign error    = (state_q == S_ERROR);
    assign fail_idx = fail_idx_q;
endmodule
